mem_wb_stage: RTL and testbench

MEM/WB pipeline register and write-back driver of the pipelined MIPS core. It captures the retiring instruction from the MEM stage and performs sub-word load extraction and extension. It selects the write-back value and drives the register-file write port (`mem_wb_instruction`, `gpr_w_sel`, `gpr_w_data`). It also exports the pending destination register for the forwarding unit and a retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 26 ++
 rtl/mem_wb_stage_load_ext.sv | 45 ++++
 rtl/mem_wb_stage.sv | 107 ++++++++++
 tb/tb_mem_wb_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: register-file write selects,
// write-back sources and the load opcodes the extractor recognises.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    GPR_NONE = 2'd0,
    GPR_RD   = 2'd1,
    GPR_RT   = 2'd2,
    GPR_RA   = 2'd3
  } gpr_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC8 = 2'd2
  } wb_src_e;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Big-endian sub-word load extractor: byte 0 lives in bits 31:24, halfword
// selection ignores addr[0] (misaligned halfwords are not trapped).
module load_ext
  import mem_wb_stage_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // lane selection from the low address bits
  always_comb begin
    byte_s = 8'h00;
    case (addr)
      2'd0:    byte_s = word[31:24];
      2'd1:    byte_s = word[23:16];
      2'd2:    byte_s = word[15:8];
      2'd3:    byte_s = word[7:0];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = word[15:0];
    end else begin
      half_s = word[31:16];
    end
  end

  // sign or zero extension by opcode
  always_comb begin
    data = word;
    case (opcode)
      OP_LB:   data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  data = {24'h000000, byte_s};
      OP_LH:   data = {{16{half_s[15]}}, half_s};
      OP_LHU:  data = {16'h0000, half_s};
      OP_LW:   data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and register-file write-back driver.
// Define LOAD_EXT_EN to enable sub-word load extraction (load_ext).
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_instruction,
  input  logic [1:0]  ex_mem_gpr_w_sel,
  input  logic [1:0]  ex_mem_wb_src,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_pc,
  input  logic [31:0] dm_rdata,
  output logic [31:0] mem_wb_instruction,
  output logic [1:0]  gpr_w_sel,
  output logic [31:0] gpr_w_data,
  output logic [4:0]  wb_dst,
  output logic        wb_fwd_valid,
  output logic [31:0] retired_count
);

  logic [31:0] mem_data_s;
  logic [31:0] wb_data_s;
  logic [1:0]  sel_s;
  logic [4:0]  dst_s;

  logic [31:0] instr_r;
  logic [1:0]  sel_r;
  logic [31:0] data_r;
  logic [4:0]  dst_r;
  logic        fwd_r;
  logic [31:0] count_r;

`ifdef LOAD_EXT_EN
  load_ext u_load_ext (
    .opcode (ex_mem_instruction[31:26]),
    .addr   (ex_mem_alu_result[1:0]),
    .word   (dm_rdata),
    .data   (mem_data_s)
  );
`else
  assign mem_data_s = dm_rdata;
`endif

  // write-back value and gated destination for the incoming instruction
  always_comb begin
    wb_data_s = 32'h0000_0000;
    case (ex_mem_wb_src)
      WB_ALU:  wb_data_s = ex_mem_alu_result;
      WB_MEM:  wb_data_s = mem_data_s;
      WB_PC8:  wb_data_s = ex_mem_pc + 32'd8;
      default: wb_data_s = 32'h0000_0000;
    endcase

    if (ex_mem_valid) begin
      sel_s = ex_mem_gpr_w_sel;
    end else begin
      sel_s = GPR_NONE;
    end

    dst_s = 5'd0;
    case (sel_s)
      GPR_RD:  dst_s = ex_mem_instruction[15:11];
      GPR_RT:  dst_s = ex_mem_instruction[20:16];
      GPR_RA:  dst_s = REG_RA;
      default: dst_s = 5'd0;
    endcase
  end

  // stage register: flush beats stall; the counter only moves on real captures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_r <= 32'h0000_0000;
      sel_r   <= GPR_NONE;
      data_r  <= 32'h0000_0000;
      dst_r   <= 5'd0;
      fwd_r   <= 1'b0;
      count_r <= 32'h0000_0000;
    end else if (flush) begin
      instr_r <= 32'h0000_0000;
      sel_r   <= GPR_NONE;
      data_r  <= 32'h0000_0000;
      dst_r   <= 5'd0;
      fwd_r   <= 1'b0;
    end else if (!stall) begin
      instr_r <= ex_mem_instruction;
      sel_r   <= sel_s;
      data_r  <= wb_data_s;
      dst_r   <= dst_s;
      fwd_r   <= (dst_s != 5'd0);
      if (ex_mem_valid) begin
        count_r <= count_r + 32'd1;
      end
    end
  end

  assign mem_wb_instruction = instr_r;
  assign gpr_w_sel          = sel_r;
  assign gpr_w_data         = data_r;
  assign wb_dst             = dst_r;
  assign wb_fwd_valid       = fwd_r;
  assign retired_count      = count_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; load-extension expectations
// follow whether LOAD_EXT_EN is defined for the build.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_instruction;
  logic [1:0]  ex_mem_gpr_w_sel;
  logic [1:0]  ex_mem_wb_src;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_pc;
  logic [31:0] dm_rdata;
  logic [31:0] mem_wb_instruction;
  logic [1:0]  gpr_w_sel;
  logic [31:0] gpr_w_data;
  logic [4:0]  wb_dst;
  logic        wb_fwd_valid;
  logic [31:0] retired_count;

  int compared = 0;
  int mismatched = 0;

  mem_wb_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .flush              (flush),
    .ex_mem_valid       (ex_mem_valid),
    .ex_mem_instruction (ex_mem_instruction),
    .ex_mem_gpr_w_sel   (ex_mem_gpr_w_sel),
    .ex_mem_wb_src      (ex_mem_wb_src),
    .ex_mem_alu_result  (ex_mem_alu_result),
    .ex_mem_pc          (ex_mem_pc),
    .dm_rdata           (dm_rdata),
    .mem_wb_instruction (mem_wb_instruction),
    .gpr_w_sel          (gpr_w_sel),
    .gpr_w_data         (gpr_w_data),
    .wb_dst             (wb_dst),
    .wb_fwd_valid       (wb_fwd_valid),
    .retired_count      (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [1:0] sel,
                       input logic [1:0] src, input logic [31:0] alu, input logic [31:0] pc);
    ex_mem_valid       = v;
    ex_mem_instruction = ins;
    ex_mem_gpr_w_sel   = sel;
    ex_mem_wb_src      = src;
    ex_mem_alu_result  = alu;
    ex_mem_pc          = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ins, input logic [1:0] sel,
                           input logic [31:0] data, input logic [4:0] dst, input logic fwd,
                           input logic [31:0] cnt);
    check({tag, ".instr"}, mem_wb_instruction, ins);
    check({tag, ".sel"},   {30'd0, gpr_w_sel}, {30'd0, sel});
    check({tag, ".data"},  gpr_w_data, data);
    check({tag, ".dst"},   {27'd0, wb_dst}, {27'd0, dst});
    check({tag, ".fwd"},   {31'd0, wb_fwd_valid}, {31'd0, fwd});
    check({tag, ".cnt"},   retired_count, cnt);
  endtask

  logic [31:0] add_rd5;
  logic [31:0] add_rd0;
  logic [31:0] i_lb, i_lbu, i_lh, i_lhu, i_lw, i_jal;
  logic [31:0] e_lb, e_lbu, e_lh, e_lhu;

  initial begin
    add_rd5 = {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20};
    add_rd0 = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20};
    i_lb    = {6'b100000, 5'd1, 5'd8, 16'h0000};
    i_lbu   = {6'b100100, 5'd1, 5'd8, 16'h0000};
    i_lh    = {6'b100001, 5'd1, 5'd8, 16'h0000};
    i_lhu   = {6'b100101, 5'd1, 5'd8, 16'h0000};
    i_lw    = {6'b100011, 5'd1, 5'd8, 16'h0000};
    i_jal   = {6'b000011, 26'h0000C00};
`ifdef LOAD_EXT_EN
    e_lb  = 32'hFFFF_FF80;
    e_lbu = 32'h0000_0080;
    e_lh  = 32'h0000_7F01;
    e_lhu = 32'h0000_7F01;
`else
    e_lb  = 32'h80FF_7F01;
    e_lbu = 32'h80FF_7F01;
    e_lh  = 32'h80FF_7F01;
    e_lhu = 32'h80FF_7F01;
`endif

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    dm_rdata = 32'h80FF_7F01;
    drive(1'b1, add_rd5, GPR_RD, WB_ALU, 32'h1234_5678, 32'h0);
    tick(); tick();
    check_all("reset", 32'h0, GPR_NONE, 32'h0, 5'd0, 1'b0, 32'd0);

    rst = 1'b0;
    tick();
    check_all("add_rd5", add_rd5, GPR_RD, 32'h1234_5678, 5'd5, 1'b1, 32'd1);

    drive(1'b1, i_lb, GPR_RT, WB_MEM, 32'h0000_1000, 32'h0);
    tick();
    check_all("lb", i_lb, GPR_RT, e_lb, 5'd8, 1'b1, 32'd2);
    drive(1'b1, i_lbu, GPR_RT, WB_MEM, 32'h0000_1000, 32'h0);
    tick();
    check("lbu.data", gpr_w_data, e_lbu);
    drive(1'b1, i_lh, GPR_RT, WB_MEM, 32'h0000_1002, 32'h0);
    tick();
    check("lh.data", gpr_w_data, e_lh);
    drive(1'b1, i_lhu, GPR_RT, WB_MEM, 32'h0000_1003, 32'h0);
    tick();
    check("lhu.data", gpr_w_data, e_lhu);
    drive(1'b1, i_lw, GPR_RT, WB_MEM, 32'h0000_1000, 32'h0);
    tick();
    check_all("lw", i_lw, GPR_RT, 32'h80FF_7F01, 5'd8, 1'b1, 32'd6);

    drive(1'b1, i_jal, GPR_RA, WB_PC8, 32'h0000_DEAD, 32'h0000_3000);
    tick();
    check_all("jal", i_jal, GPR_RA, 32'h0000_3008, 5'd31, 1'b1, 32'd7);

    // stall holds everything while the inputs change underneath
    stall = 1'b1;
    drive(1'b1, add_rd5, GPR_RD, WB_ALU, 32'h0000_AAAA, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall", i_jal, GPR_RA, 32'h0000_3008, 5'd31, 1'b1, 32'd7);
    end

    flush = 1'b1;
    tick();
    check_all("flush", 32'h0, GPR_NONE, 32'h0, 5'd0, 1'b0, 32'd7);
    stall = 1'b0; flush = 1'b0;

    drive(1'b1, add_rd0, GPR_RD, WB_ALU, 32'h0000_0055, 32'h0);
    tick();
    check_all("rd0", add_rd0, GPR_RD, 32'h0000_0055, 5'd0, 1'b0, 32'd8);

    drive(1'b1, i_lw, GPR_RT, 2'b11, 32'h0000_FFFF, 32'h0);
    tick();
    check_all("src3", i_lw, GPR_RT, 32'h0, 5'd8, 1'b1, 32'd9);

    drive(1'b0, add_rd5, GPR_RD, WB_ALU, 32'h0000_0077, 32'h0);
    tick();
    check_all("invalid", add_rd5, GPR_NONE, 32'h0000_0077, 5'd0, 1'b0, 32'd9);

    force dut.count_r = 32'hFFFF_FFFF;
    #1;
    release dut.count_r;
    check("wrap.pre", retired_count, 32'hFFFF_FFFF);
    drive(1'b1, add_rd5, GPR_RD, WB_ALU, 32'h0000_0001, 32'h0);
    tick();
    check("wrap.post", retired_count, 32'h0000_0000);
    tick();
    check("wrap.next", retired_count, 32'h0000_0001);

    // asynchronous reset away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, GPR_NONE, 32'h0, 5'd0, 1'b0, 32'd0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
